vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 2: number of lost CPU contests after which the CPU wins; legal range 1..15.
REQ-002 clk  input  1  single clock for all logic; everything samples on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 vdg_req  input  1  one-cycle pulse; the VDG requests a fetch.
REQ-005 vdg_addr  input  13  VDG fetch address; sampled when vdg_req=1.
REQ-006 vdg_data  output  8  fetched byte; holds its value until the next VDG completion.
REQ-007 vdg_valid  output  1  one-cycle pulse; vdg_data is updated.
REQ-008 vdg_overrun  output  1  sticky flag; a VDG request was overwritten before it was served.
REQ-009 cpu_req  input  1  level request; held until cpu_ack.
REQ-010 cpu_we  input  1  1 = write, 0 = read; stable while cpu_req=1.
REQ-011 cpu_addr  input  13  CPU address; stable while cpu_req=1.
REQ-012 cpu_wdata  input  8  CPU write data.
REQ-013 cpu_rdata  output  8  CPU read data; holds its value until the next CPU read completion.
REQ-014 cpu_ack  output  1  one-cycle pulse; the CPU access is complete.
REQ-015 ram_addr  output  13  RAM address, registered.
REQ-016 ram_we  output  1  RAM write strobe, registered.
REQ-017 ram_wdata  output  8  RAM write data, registered.
REQ-018 ram_rdata  input  8  synchronous RAM output, valid one cycle after ram_addr is presented.

Function
REQ-019 The FSM SHALL have three states: IDLE, ADDR and DATA. Transitions: IDLE->ADDR on grant; ADDR->DATA unconditionally; DATA->IDLE unconditionally.
REQ-020 A vdg_req pulse SHALL set vdg_pending and latch vdg_addr, in any state.
REQ-021 If vdg_req=1 while vdg_pending=1 and the pending request is not being granted in that cycle, the arbiter SHALL replace the latched address (latest wins) and set vdg_overrun.
REQ-022 A VDG grant SHALL clear vdg_pending. A vdg_req in the same cycle as a VDG grant SHALL be re-latched as a new pending request and SHALL NOT set overrun.
REQ-023 Grants SHALL be decided only in IDLE. Priority rule: the VDG wins if vdg_pending=1, unless the fairness rule (REQ-033) applies; otherwise the CPU wins if cpu_req=1.
REQ-024 In IDLE, cpu_req SHALL be ignored in the cycle in which cpu_ack=1.
REQ-025 In ADDR, ram_addr SHALL be the granted address. ram_we SHALL be 1 only for a CPU write; ram_wdata SHALL be cpu_wdata.
REQ-026 ram_we SHALL be 0 in IDLE and in DATA.
REQ-027 At the end of DATA: for a VDG grant, ram_rdata SHALL be captured into vdg_data; for a CPU read, into cpu_rdata; a CPU write SHALL capture nothing.
REQ-028 The valid/ack pulse for the completed access SHALL be asserted in the following cycle (IDLE).
REQ-029 Latency: a request granted in IDLE at cycle N SHALL complete with vdg_valid or cpu_ack at cycle N+3. Sustained throughput SHALL be one access per 3 cycles.
REQ-030 vdg_valid and cpu_ack SHALL never be high in the same cycle.

Reset
REQ-031 While reset=1, and immediately on its assertion: state=IDLE; vdg_pending=0; vdg_overrun=0; vdg_valid=0; cpu_ack=0; ram_we=0; ram_addr=0; ram_wdata=0; vdg_data=0x00; cpu_rdata=0x00; wait counter=0.
REQ-032 Reset asserted during ADDR or DATA SHALL abort the access with no ack/valid and with ram_we forced to 0.

Configuration
REQ-033 With VRAM_ARB_FAIRNESS_EN defined:
- a 4-bit saturating wait counter SHALL increment on each IDLE grant to the VDG while cpu_req=1 (excluding the REQ-024 cycle);
- when the counter is >= MAX_WAIT, the CPU SHALL win the next contest;
- the counter SHALL clear on any CPU grant.
REQ-034 Without VRAM_ARB_FAIRNESS_EN: the VDG SHALL always win, and no counter logic SHALL exist.

Verification
REQ-035 Single VDG read: RAM[0x0123]=0xA5; vdg_req with addr 0x0123 at cycle 0 -> vdg_valid=1 at cycle 3 with vdg_data=0xA5, and no ram_we.
REQ-036 CPU write then read: write 0x5A to 0x1FFF -> ram_we high exactly 1 cycle, cpu_ack at +3; read of 0x1FFF -> cpu_rdata=0x5A at ack.
REQ-037 Contention, fairness enabled, MAX_WAIT=2: cpu_req held while vdg_req pulses every 3 cycles -> grant order VDG, VDG, CPU, VDG...; the CPU is acked within 9 cycles.
REQ-038 Same stimulus without VRAM_ARB_FAIRNESS_EN -> the CPU is never acked while VDG requests continue.
REQ-039 Overrun: two vdg_req pulses (0x0010, then 0x0020) while a CPU access is in ADDR -> one vdg_valid carrying RAM[0x0020]; vdg_overrun=1 until reset.
REQ-040 Reset asserted in ADDR of a CPU write -> ram_we drops immediately, no cpu_ack, and all outputs take their REQ-031 values.

Source files
------------

// File: rtl/vram_arbiter.sv
// Purpose: shares one synchronous video RAM between a VDG (pulsed fetches) and a CPU (level requests).
// Latency: an IDLE-cycle grant completes three cycles later (ADDR, DATA, then valid/ack in IDLE).
// Backpressure: none to the VDG (the newest pending fetch replaces the old one and sets a sticky overrun); the CPU holds cpu_req until cpu_ack.
//
// Ports:
//   clk, reset                 single clock, asynchronous active-high reset
//   vdg_req/vdg_addr           VDG fetch pulse and address
//   vdg_data/vdg_valid         fetched byte and its one-cycle strobe
//   vdg_overrun                sticky: a pending VDG fetch was replaced before service
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU access request (held until cpu_ack)
//   cpu_rdata/cpu_ack          CPU read data and completion strobe
//   ram_addr/ram_we/ram_wdata  registered RAM controls
//   ram_rdata                  RAM read data, valid one cycle after ram_addr
//
// Build option: define VRAM_ARB_FAIRNESS_EN to let the CPU win after MAX_WAIT lost contests;
// without it the VDG always wins and no wait counter exists.
module vram_arbiter #(
    parameter int MAX_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vdg_req,
    input  logic [12:0] vdg_addr,
    output logic [7:0]  vdg_data,
    output logic        vdg_valid,
    output logic        vdg_overrun,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic [12:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
        $error("vram_arbiter: MAX_WAIT must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        vdg_pending;
    logic [12:0] vdg_addr_q;
    logic        inflight_vdg;   // access currently in ADDR/DATA belongs to the VDG
    logic        inflight_we;    // access currently in ADDR/DATA is a CPU write

    logic        gnt_vdg;
    logic        gnt_cpu;
    logic [12:0] gnt_addr;

    // A CPU request still high in its own ack cycle is the tail of the access just
    // completed, not a new one.
    logic        cpu_live;
    // A fresh pulse with nothing pending can be granted in the same cycle, which is
    // what gives the three-cycle pulse-to-valid latency.
    logic        vdg_want;
    logic        cpu_first;

    assign cpu_live = cpu_req & ~cpu_ack;
    assign vdg_want = vdg_pending | vdg_req;

`ifdef VRAM_ARB_FAIRNESS_EN
    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    assign cpu_first = cpu_live && (wait_cnt >= MAX_WAIT_L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (gnt_cpu) begin
            wait_cnt <= 4'd0;
        end else if (gnt_vdg && cpu_live && (wait_cnt != 4'hF)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`else
    assign cpu_first = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant decision
    always_comb begin
        state_nxt = state;
        gnt_vdg   = 1'b0;
        gnt_cpu   = 1'b0;
        gnt_addr  = cpu_addr;
        case (state)
            IDLE: begin
                if (vdg_want && !cpu_first) begin
                    gnt_vdg = 1'b1;
                end else if (cpu_live) begin
                    gnt_cpu = 1'b1;
                end
                if (gnt_vdg || gnt_cpu) begin
                    state_nxt = ADDR;
                end
            end
            ADDR:    state_nxt = DATA;
            DATA:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (gnt_vdg) begin
            gnt_addr = vdg_pending ? vdg_addr_q : vdg_addr;
        end
    end

    // VDG request latch: latest request wins; replacing an unserved one is an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vdg_pending <= 1'b0;
            vdg_addr_q  <= 13'd0;
            vdg_overrun <= 1'b0;
        end else begin
            if (vdg_req) begin
                vdg_addr_q <= vdg_addr;
            end
            if (gnt_vdg) begin
                // When the grant served the older pending request, a pulse in the same
                // cycle becomes the next pending one; otherwise the pulse itself was granted.
                vdg_pending <= vdg_req & vdg_pending;
            end else if (vdg_req) begin
                vdg_pending <= 1'b1;
            end
            if (vdg_req && vdg_pending && !gnt_vdg) begin
                vdg_overrun <= 1'b1;
            end
        end
    end

    // RAM controls and completion capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr     <= 13'd0;
            ram_we       <= 1'b0;
            ram_wdata    <= 8'd0;
            inflight_vdg <= 1'b0;
            inflight_we  <= 1'b0;
            vdg_data     <= 8'h00;
            vdg_valid    <= 1'b0;
            cpu_rdata    <= 8'h00;
            cpu_ack      <= 1'b0;
        end else begin
            // Write strobe lasts exactly the ADDR cycle.
            ram_we    <= 1'b0;
            vdg_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            if (gnt_vdg || gnt_cpu) begin
                ram_addr     <= gnt_addr;
                ram_we       <= gnt_cpu & cpu_we;
                ram_wdata    <= cpu_wdata;
                inflight_vdg <= gnt_vdg;
                inflight_we  <= gnt_cpu & cpu_we;
            end
            if (state == DATA) begin
                if (inflight_vdg) begin
                    vdg_data  <= ram_rdata;
                    vdg_valid <= 1'b1;
                end else begin
                    cpu_ack <= 1'b1;
                    if (!inflight_we) begin
                        cpu_rdata <= ram_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: table-driven single accesses plus contention,
// overrun and mid-access reset sequences, checked through an expectation queue.
module tb_vram_arbiter;

    logic        clk;
    logic        rst;
    logic        vdg_req;
    logic [12:0] vdg_addr;
    logic [7:0]  vdg_data;
    logic        vdg_valid;
    logic        vdg_overrun;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    vram_arbiter #(.MAX_WAIT(2)) dut (
        .clk         (clk),
        .reset       (rst),
        .vdg_req     (vdg_req),
        .vdg_addr    (vdg_addr),
        .vdg_data    (vdg_data),
        .vdg_valid   (vdg_valid),
        .vdg_overrun (vdg_overrun),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model
    logic [7:0] mem [0:8191];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [7:0] data;
        int         cyc;
        bit         chk;
    } exp_t;

    exp_t vdg_q[$];
    exp_t cpu_q[$];
    exp_t mon_v;
    exp_t mon_c;
    int   we_cnt  = 0;
    int   ack_cnt = 0;

    // Scoreboard: every completion strobe pops its expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) we_cnt++;
            if (vdg_valid || cpu_ack) check("valid_ack_exclusive", {31'd0, vdg_valid & cpu_ack}, 32'd0);
            if (vdg_valid) begin
                if (vdg_q.size() == 0) check("vdg_unexpected_valid", 32'd1, 32'd0);
                else begin
                    mon_v = vdg_q.pop_front();
                    check("vdg_data", {24'd0, vdg_data}, {24'd0, mon_v.data});
                    check("vdg_cycle", cyc, mon_v.cyc);
                end
            end
            if (cpu_ack) begin
                ack_cnt++;
                if (cpu_q.size() == 0) check("cpu_unexpected_ack", 32'd1, 32'd0);
                else begin
                    mon_c = cpu_q.pop_front();
                    if (mon_c.chk) check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, mon_c.data});
                    check("cpu_cycle", cyc, mon_c.cyc);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vdg_valid"},   {31'd0, vdg_valid},   32'd0);
        check({tag, "_cpu_ack"},     {31'd0, cpu_ack},     32'd0);
        check({tag, "_ram_we"},      {31'd0, ram_we},      32'd0);
        check({tag, "_ram_addr"},    {19'd0, ram_addr},    32'd0);
        check({tag, "_ram_wdata"},   {24'd0, ram_wdata},   32'd0);
        check({tag, "_vdg_data"},    {24'd0, vdg_data},    32'd0);
        check({tag, "_cpu_rdata"},   {24'd0, cpu_rdata},   32'd0);
        check({tag, "_vdg_overrun"}, {31'd0, vdg_overrun}, 32'd0);
    endtask

    // kind: 0 = VDG fetch, 1 = CPU read, 2 = CPU write
    typedef struct {
        int         kind;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int  c;
        bit  got;
        bit  acked;

        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[13'h0123] = 8'hA5;
        mem[13'h0010] = 8'h11;
        mem[13'h0020] = 8'h22;

        vecs[0] = '{0, 13'h0123, 8'h00, 8'hA5};
        vecs[1] = '{2, 13'h1FFF, 8'h5A, 8'h00};
        vecs[2] = '{1, 13'h1FFF, 8'h00, 8'h5A};
        vecs[3] = '{0, 13'h1FFF, 8'h00, 8'h5A};
        vecs[4] = '{2, 13'h0000, 8'hC3, 8'h00};
        vecs[5] = '{0, 13'h0000, 8'h00, 8'hC3};
        vecs[6] = '{1, 13'h0123, 8'h00, 8'hA5};
        vecs[7] = '{2, 13'h1000, 8'h0F, 8'h00};

        rst = 1'b1; vdg_req = 1'b0; vdg_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Single accesses, one at a time from IDLE
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            we_cnt = 0;
            c = cyc;
            if (vecs[i].kind == 0) begin
                vdg_req = 1'b1;
                vdg_addr = vecs[i].addr;
                vdg_q.push_back('{vecs[i].exp, c + 3, 1'b1});
                @(posedge clk); #1 vdg_req = 1'b0;
                for (int k = 0; k < 12 && vdg_q.size() != 0; k++) @(negedge clk);
                #1 check("vec_vdg_done", vdg_q.size(), 32'd0);
            end else begin
                cpu_req = 1'b1;
                cpu_we = (vecs[i].kind == 2);
                cpu_addr = vecs[i].addr;
                cpu_wdata = vecs[i].wdata;
                cpu_q.push_back('{vecs[i].exp, c + 3, (vecs[i].kind == 1)});
                got = 1'b0;
                for (int k = 0; k < 12 && !got; k++) begin
                    @(negedge clk);
                    got = cpu_ack;
                end
                #1 check("vec_cpu_done", cpu_q.size(), 32'd0);
                @(posedge clk); #1 cpu_req = 1'b0; cpu_we = 1'b0;
            end
            check("vec_we_cycles", we_cnt, (vecs[i].kind == 2) ? 32'd1 : 32'd0);
        end
        check("vec_write_landed", {24'd0, mem[13'h1000]}, 32'h0F);

        // Contention: CPU read held while the VDG pulses every third cycle
        acked = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk); #1;
            if (t == 0) begin
                c = cyc;
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
`ifdef VRAM_ARB_FAIRNESS_EN
                vdg_q.push_back('{8'h11, c + 3,  1'b1});
                vdg_q.push_back('{8'h11, c + 6,  1'b1});
                vdg_q.push_back('{8'h11, c + 12, 1'b1});
                vdg_q.push_back('{8'h11, c + 15, 1'b1});
                cpu_q.push_back('{8'hA5, c + 9,  1'b1});
`else
                vdg_q.push_back('{8'h11, c + 3,  1'b1});
                vdg_q.push_back('{8'h11, c + 6,  1'b1});
                vdg_q.push_back('{8'h11, c + 9,  1'b1});
                vdg_q.push_back('{8'h11, c + 12, 1'b1});
                cpu_q.push_back('{8'hA5, c + 15, 1'b1});
`endif
            end
            vdg_req = ((t % 3) == 0) && (t <= 9);
            vdg_addr = 13'h0010;
            if (acked) cpu_req = 1'b0;
            @(negedge clk);
            if (cpu_ack) acked = 1'b1;
        end
        #1;
        check("contend_vdg_drained", vdg_q.size(), 32'd0);
        check("contend_cpu_drained", cpu_q.size(), 32'd0);
        check("contend_no_overrun", {31'd0, vdg_overrun}, 32'd0);

        // Overrun: two VDG pulses while a CPU write is in ADDR then DATA
        @(posedge clk); #1;
        c = cyc;
        we_cnt = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0040; cpu_wdata = 8'h99;
        cpu_q.push_back('{8'h00, c + 3, 1'b0});
        @(posedge clk); #1 vdg_req = 1'b1; vdg_addr = 13'h0010;
        @(posedge clk); #1 vdg_addr = 13'h0020;
        @(posedge clk); #1 vdg_req = 1'b0;
        vdg_q.push_back('{8'h22, c + 6, 1'b1});
        @(posedge clk); #1 cpu_req = 1'b0; cpu_we = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("ovr_vdg_drained", vdg_q.size(), 32'd0);
        check("ovr_cpu_drained", cpu_q.size(), 32'd0);
        check("ovr_flag", {31'd0, vdg_overrun}, 32'd1);
        check("ovr_write_landed", {24'd0, mem[13'h0040]}, 32'h99);
        check("ovr_we_cycles", we_cnt, 32'd1);

        // Reset in the ADDR cycle of a CPU write aborts it
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0050; cpu_wdata = 8'hEE;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_we", {31'd0, ram_we}, 32'd1);
        check("rst_pre_addr", {19'd0, ram_addr}, 32'h50);
        c = ack_cnt;
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1 cpu_req = 1'b0; cpu_we = 1'b0; rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("rst_no_ack", ack_cnt, c);
        check("rst_no_write", {24'd0, mem[13'h0050]}, 32'h00);
        check("rst_after_overrun", {31'd0, vdg_overrun}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
